regfile_scoreboard: RTL and testbench

Parametrised register file with a built-in gated write-enable decoder and a per-register busy scoreboard for the multicycle datapath. One write port and two read ports. Read data is bypassed from a same-cycle write. A busy bit per register tracks outstanding producers, so the control FSM can stall the operand fetch until the producer writes back. It replaces the fixed 5-to-32 write-enable decoder and sits between the instruction decode stage and the writeback mux.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/onehot_dec.sv | 17 +
 rtl/regfile_scoreboard.sv | 101 ++++++++++
 tb/tb_regfile_scoreboard.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults, address type and popcount for the register file
package rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int MAX_REGS   = 256;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    // Callers zero-extend their busy vector to MAX_REGS bits.
    function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_REGS; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - parametrised gated binary-to-one-hot decoder
module onehot_dec #(
    parameter int ADDR_W = 5
) (
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    output logic [2**ADDR_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 1W2R register file with write bypass and busy scoreboard
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RegWrite,
    input  logic [ADDR_W-1:0]    WriteRegister,
    input  logic [DATA_W-1:0]    WriteData,
    input  logic [ADDR_W-1:0]    ReadRegister1,
    input  logic [ADDR_W-1:0]    ReadRegister2,
    output logic [DATA_W-1:0]    ReadData1,
    output logic [DATA_W-1:0]    ReadData2,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_reg,
    output logic                 busy1,
    output logic                 busy2,
    output logic                 stall,
    output logic [ADDR_W:0]      busy_count,
    output logic [2**ADDR_W-1:0] WriteEn
);

    localparam int NREGS = 2**ADDR_W;
    localparam logic [NREGS-1:0] ZERO_MASK = (ZERO_REG != 0) ? NREGS'(1) : '0;

    logic [NREGS-1:0]  dec_raw;
    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;
    logic              issue_ok;

    onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
        .en     (RegWrite),
        .addr   (WriteRegister),
        .onehot (dec_raw)
    );

    assign WriteEn = dec_raw & ~ZERO_MASK;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (WriteEn[i]) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

    always_comb begin
        ReadData1 = regs[ReadRegister1];
        if (reset || (ZERO_REG != 0 && ReadRegister1 == '0)) begin
            ReadData1 = '0;
        end else if (RegWrite && WriteRegister == ReadRegister1) begin
            ReadData1 = WriteData;
        end
    end

    always_comb begin
        ReadData2 = regs[ReadRegister2];
        if (reset || (ZERO_REG != 0 && ReadRegister2 == '0)) begin
            ReadData2 = '0;
        end else if (RegWrite && WriteRegister == ReadRegister2) begin
            ReadData2 = WriteData;
        end
    end

    // Issue is applied after the writeback clear so a new producer wins.
    assign issue_ok = issue_valid && !(ZERO_REG != 0 && issue_reg == '0);

    always_comb begin
        busy_next = busy & ~WriteEn;
        if (issue_ok) begin
            busy_next[issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= (ADDR_W+1)'(popcount(MAX_REGS'(busy_next)));
        end
    end

    // A same-cycle writeback releases the stall, matching the data bypass.
    assign busy1 = busy[ReadRegister1] & ~(RegWrite & (WriteRegister == ReadRegister1)) & ~reset;
    assign busy2 = busy[ReadRegister2] & ~(RegWrite & (WriteRegister == ReadRegister2)) & ~reset;
    assign stall = busy1 | busy2;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1, ReadRegister2;
    logic [31:0] ReadData1, ReadData2;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic        busy1, busy2, stall;
    logic [5:0]  busy_count;
    logic [31:0] WriteEn;

    logic        s_reset;
    logic        s_RegWrite;
    logic [2:0]  s_WriteRegister;
    logic [15:0] s_WriteData;
    logic [2:0]  s_ReadRegister1, s_ReadRegister2;
    logic [15:0] s_ReadData1, s_ReadData2;
    logic        s_issue_valid;
    logic [2:0]  s_issue_reg;
    logic        s_busy1, s_busy2, s_stall;
    logic [3:0]  s_busy_count;
    logic [7:0]  s_WriteEn;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] expv;
    logic [31:0] mb;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .issue_valid(issue_valid),
        .issue_reg(issue_reg), .busy1(busy1), .busy2(busy2), .stall(stall),
        .busy_count(busy_count), .WriteEn(WriteEn)
    );

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut8 (
        .clk(clk), .reset(s_reset), .RegWrite(s_RegWrite), .WriteRegister(s_WriteRegister),
        .WriteData(s_WriteData), .ReadRegister1(s_ReadRegister1), .ReadRegister2(s_ReadRegister2),
        .ReadData1(s_ReadData1), .ReadData2(s_ReadData2), .issue_valid(s_issue_valid),
        .issue_reg(s_issue_reg), .busy1(s_busy1), .busy2(s_busy2), .stall(s_stall),
        .busy_count(s_busy_count), .WriteEn(s_WriteEn)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd2; WriteData = 32'hA5A5A5A5;
        ReadRegister1 = 5'd2; ReadRegister2 = 5'd0; issue_valid = 1'b0; issue_reg = '0;
        #2;
        checks++; if (WriteEn !== 32'h4) begin errors++; $display("FAIL reset_writeen got=%h exp=%h", WriteEn, 32'h4); end
        checks++; if (ReadData1 !== 32'h0) begin errors++; $display("FAIL reset_readdata got=%h exp=0", ReadData1); end
        tick();
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL reset_busy_count got=%0d exp=0", busy_count); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        RegWrite = 1'b0;
        tick();
        reset = 1'b0;
        mb = '0;
        #1;
        checks++; if (ReadData1 !== 32'h0) begin errors++; $display("FAIL reset_reg2_cleared got=%h exp=0", ReadData1); end
    endtask

    task automatic test_write_read();
        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        #1;
        checks++; if (WriteEn !== 32'h00000020) begin errors++; $display("FAIL write_r5_writeen got=%h exp=%h", WriteEn, 32'h20); end
        tick();
        RegWrite = 1'b0; ReadRegister1 = 5'd5;
        #1;
        expv = exp_q.pop_front();
        checks++; if (ReadData1 !== expv) begin errors++; $display("FAIL read_r5 got=%h exp=%h", ReadData1, expv); end
    endtask

    task automatic test_zero_reg();
        RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'hFFFFFFFF; ReadRegister1 = 5'd0;
        #1;
        checks++; if (WriteEn !== 32'h0) begin errors++; $display("FAIL zero_writeen got=%h exp=0", WriteEn); end
        checks++; if (ReadData1 !== 32'h0) begin errors++; $display("FAIL zero_read_during got=%h exp=0", ReadData1); end
        tick();
        RegWrite = 1'b0;
        #1;
        checks++; if (ReadData1 !== 32'h0) begin errors++; $display("FAIL zero_read_after got=%h exp=0", ReadData1); end
    endtask

    task automatic test_bypass();
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'h1234; ReadRegister2 = 5'd7;
        exp_q.push_back(32'h1234);
        #1;
        checks++; if (ReadData2 !== 32'h1234) begin errors++; $display("FAIL bypass_r7 got=%h exp=%h", ReadData2, 32'h1234); end
        tick();
        RegWrite = 1'b0;
        #1;
        expv = exp_q.pop_front();
        checks++; if (ReadData2 !== expv) begin errors++; $display("FAIL stored_r7 got=%h exp=%h", ReadData2, expv); end
    endtask

    task automatic test_busy();
        issue_valid = 1'b1; issue_reg = 5'd9;
        #1;
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL issue_latency got=%0d exp=0", busy_count); end
        tick();
        issue_valid = 1'b0; ReadRegister1 = 5'd9; mb[9] = 1'b1;
        #1;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL busy1_r9 got=%b exp=1", busy1); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_r9 got=%b exp=1", stall); end
        checks++; if (busy_count !== 6'($countones(mb))) begin errors++; $display("FAIL count_r9 got=%0d exp=%0d", busy_count, $countones(mb)); end
        RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 32'h99;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_wb_r9 got=%b exp=0", stall); end
        tick();
        RegWrite = 1'b0; mb[9] = 1'b0;
        #1;
        checks++; if (busy_count !== 6'($countones(mb))) begin errors++; $display("FAIL count_after_wb got=%0d exp=%0d", busy_count, $countones(mb)); end
    endtask

    task automatic test_issue_write();
        issue_valid = 1'b1; issue_reg = 5'd3; RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'h33;
        tick();
        mb[3] = 1'b1;
        issue_reg = 5'd4; WriteRegister = 5'd6; WriteData = 32'h66;
        ReadRegister1 = 5'd3;
        #1;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL set_wins_r3 got=%b exp=1", busy1); end
        tick();
        mb[4] = 1'b1;
        issue_valid = 1'b0; RegWrite = 1'b0; ReadRegister1 = 5'd4; ReadRegister2 = 5'd6;
        #1;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL issue_r4 got=%b exp=1", busy1); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL write_r6_not_busy got=%b exp=0", busy2); end
        checks++; if (busy_count !== 6'($countones(mb))) begin errors++; $display("FAIL count_r3_r4 got=%0d exp=%0d", busy_count, $countones(mb)); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            RegWrite = 1'b1; WriteRegister = 5'(16 + i); WriteData = $urandom;
            exp_q.push_back(WriteData);
            tick();
        end
        RegWrite = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ReadRegister1 = 5'(16 + i);
            #1;
            expv = exp_q.pop_front();
            checks++; if (ReadData1 !== expv) begin errors++; $display("FAIL b2b_r%0d got=%h exp=%h", 16 + i, ReadData1, expv); end
        end
    endtask

    task automatic test_async_reset();
        foreach (issue_reg[k]) ;
        issue_valid = 1'b1;
        issue_reg = 5'd1;  tick();
        issue_reg = 5'd2;  tick();
        issue_reg = 5'd31; tick();
        issue_valid = 1'b0;
        mb[1] = 1'b1; mb[2] = 1'b1; mb[31] = 1'b1;
        ReadRegister1 = 5'd1; ReadRegister2 = 5'd5;
        #1;
        checks++; if (busy_count !== 6'($countones(mb))) begin errors++; $display("FAIL count_pre_reset got=%0d exp=%0d", busy_count, $countones(mb)); end
        #2;
        reset = 1'b1;
        mb = '0;
        #1;
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL async_count got=%0d exp=0", busy_count); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL async_stall got=%b exp=0", stall); end
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            #1;
            checks++; if (ReadData1 !== 32'h0) begin errors++; $display("FAIL async_r%0d got=%h exp=0", i, ReadData1); end
        end
        tick();
        reset = 1'b0;
        RegWrite = 1'b1; WriteRegister = 5'd12; WriteData = 32'h55;
        exp_q.push_back(32'h55);
        tick();
        RegWrite = 1'b0; ReadRegister1 = 5'd12;
        #1;
        expv = exp_q.pop_front();
        checks++; if (ReadData1 !== expv) begin errors++; $display("FAIL first_write_after_reset got=%h exp=%h", ReadData1, expv); end
    endtask

    task automatic test_small();
        s_reset = 1'b1; s_RegWrite = 1'b0; s_WriteRegister = '0; s_WriteData = '0;
        s_ReadRegister1 = '0; s_ReadRegister2 = '0; s_issue_valid = 1'b0; s_issue_reg = '0;
        tick();
        s_reset = 1'b0;
        s_RegWrite = 1'b1; s_WriteRegister = 3'd5; s_WriteData = 16'h5A5A;
        #1;
        checks++; if (s_WriteEn !== 8'h20) begin errors++; $display("FAIL small_writeen got=%h exp=20", s_WriteEn); end
        tick();
        s_RegWrite = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_issue_valid = 1'b1; s_issue_reg = 3'(i);
            tick();
        end
        s_issue_valid = 1'b1; s_issue_reg = 3'd6;
        tick();
        s_issue_valid = 1'b0; s_ReadRegister1 = 3'd0; s_ReadRegister2 = 3'd7;
        #1;
        checks++; if (s_busy_count !== 4'd7) begin errors++; $display("FAIL small_count_sat got=%0d exp=7", s_busy_count); end
        checks++; if (s_busy1 !== 1'b0) begin errors++; $display("FAIL small_r0_busy got=%b exp=0", s_busy1); end
        checks++; if (s_busy2 !== 1'b1) begin errors++; $display("FAIL small_r7_busy got=%b exp=1", s_busy2); end
        s_RegWrite = 1'b1; s_WriteRegister = 3'd3; s_WriteData = 16'hBEEF;
        exp_q.push_back(32'h0000BEEF);
        tick();
        s_RegWrite = 1'b0; s_ReadRegister1 = 3'd3;
        #1;
        expv = exp_q.pop_front();
        checks++; if (s_busy_count !== 4'd6) begin errors++; $display("FAIL small_count_wb got=%0d exp=6", s_busy_count); end
        checks++; if ({16'h0, s_ReadData1} !== expv) begin errors++; $display("FAIL small_read_r3 got=%h exp=%h", s_ReadData1, expv); end
    endtask

    initial begin
        s_reset = 1'b1; s_RegWrite = 1'b0; s_WriteRegister = '0; s_WriteData = '0;
        s_ReadRegister1 = '0; s_ReadRegister2 = '0; s_issue_valid = 1'b0; s_issue_reg = '0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_busy();
        test_issue_write();
        test_back_to_back();
        test_async_reset();
        test_small();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
